// File: rtl/ecc_hamming_encoder_pipe.sv
// Two-stage valid/ready Hamming/SECDED encoder; codeword index = Hamming position - 1.
// Optional error injection is compiled in when ECC_ENCODER_ERR_INJECT_EN is defined.
module ecc_hamming_encoder_pipe #(
    parameter int D      = 4,
    parameter int DW     = D,
    parameter int C      = 7,
    parameter int SECDED = 1,
    parameter int P      = C - D,
    parameter int CW     = DW + P
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] din,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] codeword,
    output logic          extra_parity
`ifdef ECC_ENCODER_ERR_INJECT_EN
    ,
    input  logic          inj_req,
    input  logic [CW-1:0] inj_mask,
    output logic          inj_pending
`endif
);

    // Codeword index of the n-th data bit: n-th non-power-of-two Hamming position.
    function automatic int unsigned data_index(input int unsigned n);
        int unsigned cnt;
        int unsigned idx;
        cnt = 0;
        idx = 0;
        for (int unsigned pos = 1; pos <= C; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (cnt == n) idx = pos - 1;
                cnt++;
            end
        end
        return idx;
    endfunction

    // Data positions covered by parity bit i.
    function automatic logic [C-1:0] parity_mask(input int unsigned i);
        logic [C-1:0] m;
        m = '0;
        for (int unsigned pos = 1; pos <= C; pos++) begin
            if ((((pos >> i) & 1) != 0) && ((pos & (pos - 1)) != 0))
                m = m | (C'(1) << (pos - 1));
        end
        return m;
    endfunction

    logic          s1_valid;
    logic [DW-1:0] s1_data;
    logic          s2_valid;
    logic          s2_load;
    logic [C-1:0]  spread;
    logic [C-1:0]  cw_full;
    logic [CW-1:0] cw_next;
    logic          ep_next;
    logic [CW-1:0] inj_flip;

    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    // Shortened-code data bits DW..D-1 and all parity slots start as zero.
    for (genvar g = 0; g < D; g++) begin : g_data
        if (g < DW) begin : g_used
            assign spread[data_index(g)] = s1_data[g];
        end else begin : g_pad
            assign spread[data_index(g)] = 1'b0;
        end
    end

    for (genvar q = 0; q < P; q++) begin : g_pslot
        assign spread[(1 << q) - 1] = 1'b0;
    end

    always_comb begin
        cw_full = spread;
        for (int unsigned i = 0; i < P; i++) begin
            cw_full = cw_full | (C'(^(spread & parity_mask(i))) << ((1 << i) - 1));
        end
        cw_next = cw_full[CW-1:0];
        ep_next = (SECDED != 0) ? ^cw_next : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_data  <= din;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

`ifdef ECC_ENCODER_ERR_INJECT_EN
    logic [CW-1:0] inj_mask_q;
    logic          inj_pending_q;

    // A new arm request wins over consumption, so it targets the following word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inj_pending_q <= 1'b0;
            inj_mask_q    <= '0;
        end else if (inj_req) begin
            inj_pending_q <= 1'b1;
            inj_mask_q    <= inj_mask;
        end else if (s2_load) begin
            inj_pending_q <= 1'b0;
        end
    end

    assign inj_flip    = inj_pending_q ? inj_mask_q : '0;
    assign inj_pending = inj_pending_q;
`else
    assign inj_flip = '0;
`endif

    // extra_parity is taken from the clean codeword so injected flips stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            codeword     <= '0;
            extra_parity <= 1'b0;
        end else if (s2_load) begin
            s2_valid     <= 1'b1;
            codeword     <= cw_next ^ inj_flip;
            extra_parity <= ep_next;
        end else if (out_ready) begin
            s2_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ecc_hamming_encoder_pipe.sv
// Scoreboard bench for ecc_hamming_encoder_pipe: default (4,7) instance plus a shortened (8 of 11, 15) instance.
// Injection scenario is included when ECC_ENCODER_ERR_INJECT_EN is defined.
module tb_ecc_hamming_encoder_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, extra_parity;
    logic [3:0] din;
    logic [6:0] codeword;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_extra_parity;
    logic [7:0]  s_din;
    logic [11:0] s_codeword;

`ifdef ECC_ENCODER_ERR_INJECT_EN
    logic       inj_req, inj_pending;
    logic [6:0] inj_mask;
`endif

    ecc_hamming_encoder_pipe #(.D(4), .C(7), .SECDED(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready),
        .codeword(codeword), .extra_parity(extra_parity)
`ifdef ECC_ENCODER_ERR_INJECT_EN
        , .inj_req(inj_req), .inj_mask(inj_mask), .inj_pending(inj_pending)
`endif
    );

`ifdef ECC_ENCODER_ERR_INJECT_EN
    logic        s_inj_pending;
    logic [11:0] s_inj_mask;
    assign s_inj_mask = '0;
`endif

    ecc_hamming_encoder_pipe #(.D(11), .DW(8), .C(15), .SECDED(1)) dut_short (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .din(s_din),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .codeword(s_codeword), .extra_parity(s_extra_parity)
`ifdef ECC_ENCODER_ERR_INJECT_EN
        , .inj_req(1'b0), .inj_mask(s_inj_mask), .inj_pending(s_inj_pending)
`endif
    );

    // Hand-computed (7,4) codewords and overall parity for data 0..15.
    logic [6:0] cw_tab [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};
    logic       ep_tab [16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    typedef struct packed {
        logic [6:0] cw;
        logic       ep;
        logic [2:0] syn;
        logic [3:0] data;
    } exp_t;

    typedef struct packed {
        logic [11:0] cw;
        logic        ep;
        logic [7:0]  data;
    } sexp_t;

    exp_t  sb[$];
    sexp_t ssb[$];
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] syndrome(input logic [14:0] cw);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < 15; i++) if (cw[i]) s = s ^ 4'(i + 1);
        return s;
    endfunction

    // Main monitor: holds against the queue head while stalled, pops and decodes on transfer.
    always @(negedge clk) begin : mon_main
        exp_t       e;
        logic [2:0] syn;
        logic [6:0] corr;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'(0));
            end else begin
                e = sb[0];
                check(out_ready ? "codeword" : "hold_codeword", 32'(codeword), 32'(e.cw));
                check(out_ready ? "extra_parity" : "hold_extra_parity", 32'(extra_parity), 32'(e.ep));
                if (out_ready) begin
                    void'(sb.pop_front());
                    syn  = 3'(syndrome({8'h00, codeword}));
                    corr = codeword;
                    if (syn != 0) corr = codeword ^ (7'(1) << (syn - 3'd1));
                    check("dec_syndrome", 32'(syn), 32'(e.syn));
                    check("dec_single_err", 32'(^{codeword, extra_parity}), 32'(e.syn != 0));
                    check("dec_data", 32'({corr[6], corr[5], corr[4], corr[2]}), 32'(e.data));
                end
            end
        end
    end

    always @(negedge clk) begin : mon_short
        sexp_t e;
        if (rst_n && s_out_valid && s_out_ready) begin
            if (ssb.size() == 0) begin
                check("short_unexpected_output", 32'(s_out_valid), 32'(0));
            end else begin
                e = ssb.pop_front();
                check("short_codeword", 32'(s_codeword), 32'(e.cw));
                check("short_extra_parity", 32'(s_extra_parity), 32'(e.ep));
                check("short_syndrome", 32'(syndrome({3'b000, s_codeword})), 32'(0));
                check("short_dec_data", 32'({s_codeword[11:8], s_codeword[6:4], s_codeword[2]}),
                      32'(e.data));
            end
        end
    end

    task automatic send(input logic [3:0] d, input logic [6:0] cw, input logic ep,
                        input logic [2:0] syn, output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        in_valid = 1'b1;
        din = d;
        while (!ok && stalls < 200) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            check("in_ready_timeout", 32'(in_ready), 32'(1));
        end else begin
            sb.push_back('{cw, ep, syn, d});
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_tab(input int n, output int stalls);
        send(4'(n), cw_tab[n], ep_tab[n], 3'd0, stalls);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || ssb.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_main", 32'(sb.size()), 32'(0));
        check("drain_short", 32'(ssb.size()), 32'(0));
    endtask

    task automatic send_short(input logic [7:0] d, input logic [11:0] cw, input logic ep);
        s_in_valid = 1'b1;
        s_din = d;
        @(negedge clk);
        check("short_in_ready", 32'(s_in_ready), 32'(1));
        ssb.push_back('{cw, ep, d});
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int st;
        int total;
        in_valid = 1'b0;
        din = '0;
        out_ready = 1'b1;
        s_in_valid = 1'b0;
        s_din = '0;
        s_out_ready = 1'b1;
`ifdef ECC_ENCODER_ERR_INJECT_EN
        inj_req = 1'b0;
        inj_mask = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_codeword", 32'(codeword), 32'(0));
        check("rst_extra_parity", 32'(extra_parity), 32'(0));
        check("rst_short_out_valid", 32'(s_out_valid), 32'(0));
        @(posedge clk);
        #1;

        // Basic vectors
        send(4'b1011, 7'h55, 1'b0, 3'd0, st);
        send(4'hF, 7'h7F, 1'b1, 3'd0, st);
        send(4'h0, 7'h00, 1'b0, 3'd0, st);
        drain();

        // Latency: accepted at edge N, out_valid visible after edge N+1
        in_valid = 1'b1;
        din = 4'h6;
        sb.push_back('{cw_tab[6], ep_tab[6], 3'd0, 4'h6});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_not_yet", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        check("lat_valid", 32'(out_valid), 32'(1));
        drain();

        // Streaming 0..15 with in_ready never dropping
        total = 0;
        for (int n = 0; n < 16; n++) begin
            send_tab(n, st);
            total += st;
        end
        check("stream_stalls", 32'(total), 32'(0));
        drain();

        // Backpressure
        out_ready = 1'b0;
        send_tab(3, st);
        send_tab(4, st);
        in_valid = 1'b1;
        din = 4'h5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'(0));
            check("bp_out_valid", 32'(out_valid), 32'(1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_tab(5, st);
        send_tab(6, st);
        drain();

        // Shortened SECDED instance
        send_short(8'hA5, 12'hA27, 1'b0);
        send_short(8'h01, 12'h007, 1'b1);
        drain();

`ifdef ECC_ENCODER_ERR_INJECT_EN
        inj_req = 1'b1;
        inj_mask = 7'b0000100;
        @(posedge clk);
        #1;
        inj_req = 1'b0;
        inj_mask = '0;
        @(negedge clk);
        check("inj_armed", 32'(inj_pending), 32'(1));
        @(posedge clk);
        #1;
        send(4'b1011, 7'h51, 1'b0, 3'd3, st);
        drain();
        check("inj_cleared", 32'(inj_pending), 32'(0));
        send(4'b1011, 7'h55, 1'b0, 3'd0, st);
        drain();
`endif

        // Reset with both stages full
        out_ready = 1'b0;
        send_tab(1, st);
        send_tab(2, st);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_out_valid", 32'(out_valid), 32'(0));
        check("postrst_in_ready", 32'(in_ready), 32'(1));
        check("postrst_codeword", 32'(codeword), 32'(0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(4'b1011, 7'h55, 1'b0, 3'd0, st);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
